// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: stall/flush handshake between the pipeline stages and the central scheduler.
// Counter signals exist only when CTRL_PERF_EN is defined.
interface pipeline_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic        tlb_refetch_i;
    logic [31:0] refetch_pc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
`ifdef CTRL_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excepttype_i, cp0_epc_i, tlb_refetch_i, refetch_pc_i,
        input  stall, flush, new_pc, stall_cycles_o, flush_count_o
    );
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excepttype_i, cp0_epc_i, tlb_refetch_i, refetch_pc_i,
        output stall, flush, new_pc, stall_cycles_o, flush_count_o
    );
`else
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excepttype_i, cp0_epc_i, tlb_refetch_i, refetch_pc_i,
        input  stall, flush, new_pc
    );
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excepttype_i, cp0_epc_i, tlb_refetch_i, refetch_pc_i,
        output stall, flush, new_pc
    );
`endif
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall arbitration and exception/ERET/TLB-refetch redirect sequencing for the MIPS32 pipeline.
// Optional performance counters are enabled by defining CTRL_PERF_EN.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input logic           clk,
    input logic           rst,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, PEND, BLANK} state_t;
    state_t      state, state_n;
    logic [31:0] pend_pc, pend_pc_n, target;
    logic [5:0]  req_stall, stall;
    logic        redirect, flush;
    logic [31:0] new_pc;
    always_comb begin
        req_stall = bus.stallreq_mem ? 6'b011111 :
                    bus.stallreq_ex  ? 6'b001111 :
                    bus.stallreq_id  ? 6'b000111 :
                    bus.stallreq_if  ? 6'b000011 : 6'b000000;
        redirect  = (bus.excepttype_i != 32'd0) || bus.tlb_refetch_i;
        target    = (bus.excepttype_i == 32'h0000_000E) ? bus.cp0_epc_i :
                    (bus.excepttype_i != 32'd0)        ? EXC_VECTOR :
                                                         bus.refetch_pc_i + 32'd4;
        state_n   = state;
        pend_pc_n = pend_pc;
        stall     = req_stall;
        flush     = 1'b0;
        new_pc    = 32'd0;
        if (rst) begin
            state_n   = RUN;
            pend_pc_n = 32'd0;
            stall     = 6'b000000;
        end else begin
            case (state)
                RUN: if (redirect) begin
                    if (bus.stallreq_mem) begin
                        pend_pc_n = target;
                        state_n   = PEND;
                    end else begin
                        flush   = 1'b1;
                        new_pc  = target;
                        stall   = 6'b000000;
                        state_n = BLANK;
                    end
                end
                PEND: if (!bus.stallreq_mem) begin
                    // PC must load new_pc, so nothing may hold during the flush
                    flush   = 1'b1;
                    new_pc  = pend_pc;
                    stall   = 6'b000000;
                    state_n = BLANK;
                end
                BLANK: begin
                    stall   = bus.stallreq_if ? 6'b000011 : 6'b000000;
                    state_n = RUN;
                end
                default: state_n = RUN;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            pend_pc <= 32'd0;
        end else begin
            state   <= state_n;
            pend_pc <= pend_pc_n;
        end
    end
    assign bus.stall  = stall;
    assign bus.flush  = flush;
    assign bus.new_pc = new_pc;
`ifdef CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 16'd0;
        end else begin
            if (stall != 6'd0 && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
            if (flush) flush_count <= flush_count + 16'd1;
        end
    end
    assign bus.stall_cycles_o = stall_cycles;
    assign bus.flush_count_o  = flush_count;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: randomized and directed checks of pipeline_ctrl against a queue-based reference model.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    pipeline_ctrl_if bus ();
    pipeline_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int vectors = 0, errors = 0;
    logic [31:0] pend_q[$];
    bit          after_flush;
    longint      sc_m;
    int          fc_m;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        bus.stallreq_if = 0; bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
        bus.excepttype_i = 0; bus.cp0_epc_i = 0; bus.tlb_refetch_i = 0; bus.refetch_pc_i = 0;
    endtask

    // Called after inputs settle mid-cycle: predict outputs, compare, then advance the model past the next edge.
    task automatic eval();
        logic [31:0] tgt;
        bit ev, nxt_after;
        #1;
        e_stall = bus.stallreq_mem ? 6'h1F : bus.stallreq_ex ? 6'h0F :
                  bus.stallreq_id ? 6'h07 : bus.stallreq_if ? 6'h03 : 6'h00;
        e_flush = 0;
        e_pc = 0;
        nxt_after = 0;
        ev = (bus.excepttype_i != 0) || bus.tlb_refetch_i;
        tgt = (bus.excepttype_i == 32'hE) ? bus.cp0_epc_i :
              (bus.excepttype_i != 0) ? 32'h8000_0180 : bus.refetch_pc_i + 32'd4;
        if (rst) begin
            e_stall = 0;
        end else if (after_flush) begin
            e_stall = bus.stallreq_if ? 6'h03 : 6'h00;
        end else if (pend_q.size() != 0) begin
            if (!bus.stallreq_mem) begin
                e_flush = 1; e_pc = pend_q.pop_front(); e_stall = 0; nxt_after = 1;
            end
        end else if (ev) begin
            if (bus.stallreq_mem) pend_q.push_back(tgt);
            else begin
                e_flush = 1; e_pc = tgt; e_stall = 0; nxt_after = 1;
            end
        end
        chk("stall", {26'd0, bus.stall}, {26'd0, e_stall});
        chk("flush", {31'd0, bus.flush}, {31'd0, e_flush});
        chk("new_pc", bus.new_pc, e_pc);
`ifdef CTRL_PERF_EN
        chk("stall_cycles", bus.stall_cycles_o, sc_m[31:0]);
        chk("flush_count", {16'd0, bus.flush_count_o}, fc_m & 32'hFFFF);
`endif
        if (rst) begin
            pend_q.delete(); after_flush = 0; sc_m = 0; fc_m = 0;
        end else begin
            after_flush = nxt_after;
            if (e_stall != 0 && sc_m < 64'hFFFF_FFFF) sc_m++;
            if (e_flush) fc_m++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        eval();
    endtask

    initial begin
        int r;
        rst = 1; idle_in();
        pend_q.delete(); after_flush = 0; sc_m = 0; fc_m = 0;
        step(); step();
        chk("reset_stall", {26'd0, bus.stall}, 32'd0);
        chk("reset_flush", {31'd0, bus.flush}, 32'd0);
        @(negedge clk); rst = 0; eval();

        @(negedge clk); bus.stallreq_ex = 1; bus.stallreq_if = 1; eval();
        chk("lit_ex_if_stall", {26'd0, bus.stall}, 32'h0F);
        chk("lit_ex_if_flush", {31'd0, bus.flush}, 32'd0);
        @(negedge clk); idle_in(); eval();
        chk("lit_drop_stall", {26'd0, bus.stall}, 32'd0);

        @(negedge clk); bus.excepttype_i = 32'h8; eval();
        chk("lit_exc_flush", {31'd0, bus.flush}, 32'd1);
        chk("lit_exc_pc", bus.new_pc, 32'h8000_0180);
        chk("lit_exc_stall", {26'd0, bus.stall}, 32'd0);
        @(negedge clk); idle_in(); bus.stallreq_mem = 1; eval();
        chk("lit_blank_stall", {26'd0, bus.stall}, 32'd0);
        @(negedge clk); idle_in(); eval();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.stallreq_mem = 1; bus.excepttype_i = 32'hE;
            bus.cp0_epc_i = (i == 0) ? 32'hBFC0_0100 : 32'h1234_0000 + i;
            eval();
            chk("lit_eret_hold_stall", {26'd0, bus.stall}, 32'h1F);
            chk("lit_eret_hold_flush", {31'd0, bus.flush}, 32'd0);
        end
        @(negedge clk); idle_in(); bus.cp0_epc_i = 32'hDEAD_BEEF; eval();
        chk("lit_eret_flush", {31'd0, bus.flush}, 32'd1);
        chk("lit_eret_pc", bus.new_pc, 32'hBFC0_0100);
        @(negedge clk); idle_in(); eval();

        @(negedge clk); bus.tlb_refetch_i = 1; bus.refetch_pc_i = 32'hFFFF_FFFC; eval();
        chk("lit_wrap_flush", {31'd0, bus.flush}, 32'd1);
        chk("lit_wrap_pc", bus.new_pc, 32'h0);
        @(negedge clk); idle_in(); eval();

        @(negedge clk); bus.stallreq_mem = 1; bus.excepttype_i = 32'h8; eval();
        @(negedge clk); rst = 1; idle_in(); eval();
        @(negedge clk); rst = 0; eval();
        chk("lit_rst_pend_flush", {31'd0, bus.flush}, 32'd0);
        @(negedge clk); bus.excepttype_i = 32'h8; eval();
        chk("lit_rst_pend_run", {31'd0, bus.flush}, 32'd1);
        @(negedge clk); idle_in(); eval();

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            bus.stallreq_if  = ($urandom_range(0, 3) == 0);
            bus.stallreq_id  = ($urandom_range(0, 5) == 0);
            bus.stallreq_ex  = ($urandom_range(0, 5) == 0);
            bus.stallreq_mem = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 15);
            bus.excepttype_i = (r < 13) ? 32'd0 : (r == 13) ? 32'hE : (r == 14) ? ($urandom | 32'd1) : 32'h8;
            bus.cp0_epc_i = $urandom;
            bus.tlb_refetch_i = ($urandom_range(0, 9) == 0);
            bus.refetch_pc_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            eval();
        end

`ifdef CTRL_PERF_EN
        @(negedge clk); rst = 1; idle_in(); eval();
        @(negedge clk); rst = 0; eval();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle_in(); bus.stallreq_if = 1; eval();
        end
        @(negedge clk); idle_in(); bus.excepttype_i = 32'h8; eval();
        @(negedge clk); idle_in(); eval();
        @(negedge clk); bus.tlb_refetch_i = 1; eval();
        @(negedge clk); idle_in(); eval();
        chk("lit_perf_stalls", bus.stall_cycles_o, 32'd5);
        chk("lit_perf_flushes", {16'd0, bus.flush_count_o}, 32'd2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush scheduler for the five-stage MIPS32 pipeline. Arbitrates stall requests from IF, ID, EX and MEM into the 6-bit `stall` vector consumed by PC and all inter-stage registers, including MEM_WB. Sequences exception, ERET and TLB-write refetch redirects into a one-cycle `flush` pulse plus `new_pc`. Defers redirects that arrive while MEM is stalled.

## Interface
- `EXC_VECTOR`, default 32'h8000_0180: general exception entry address.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stallreq_if` input 1: instruction bus wait.
- `stallreq_id` input 1: load-use hazard.
- `stallreq_ex` input 1: multiply/divide busy.
- `stallreq_mem` input 1: data bus wait.
- `excepttype_i` input 32: MEM-stage exception code; 0 means none. 32'h0E means ERET; any other nonzero value is a trap to `EXC_VECTOR`.
- `cp0_epc_i` input 32: current EPC, used for ERET.
- `tlb_refetch_i` input 1: tlbwi/tlbwr retiring from MEM.
- `refetch_pc_i` input 32: PC of that TLB instruction.
- `stall` output 6: bit 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
- `flush` output 1: clears all pipeline registers this edge.
- `new_pc` output 32: redirect target, valid when `flush`=1.
- `stall_cycles_o` output 32: only present with `CTRL_PERF_EN`.
- `flush_count_o` output 16: only present with `CTRL_PERF_EN`.

## Operation
- **Stall encoding.** The request from the highest stage wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- Stage k+1 sees `stall[k]`=1 and `stall[k+1]`=0 and therefore inserts a bubble.
- **FSM states:** RUN, PEND, BLANK.
- **RUN.**
  - A redirect event is `excepttype_i`≠0, or `tlb_refetch_i`=1. The exception has priority over the refetch.
  - Event with `stallreq_mem`=0: `flush`=1 and `stall`=0 in the same cycle (combinational). Next state is BLANK.
  - Event with `stallreq_mem`=1: latch the target into `pend_pc`, assert no flush, and set `stall` normally. Next state is PEND.
- **Target selection.**
  - ERET → `cp0_epc_i`.
  - Other exception → `EXC_VECTOR`.
  - Refetch → `refetch_pc_i` + 4, modulo 2^32.
- **PEND.**
  - `stall` follows the requests.
  - A new event while in PEND does not overwrite the latched target; first event wins.
  - When `stallreq_mem`=0: `flush`=1, `new_pc`=`pend_pc`, next state is BLANK.
- **BLANK** (exactly one cycle after each flush).
  - `stallreq_id`, `stallreq_ex`, `stallreq_mem` and events are ignored, because those stages hold bubbles.
  - `stallreq_if` is honoured.
  - Next state is RUN.
- `new_pc` = 0 whenever `flush`=0.

## Timing
- Stall and flush have zero-cycle latency from a request in RUN.
- Deferred flush occurs in the first cycle with `stallreq_mem`=0.
- Reset values:
  - `stall`=0, `flush`=0, `new_pc`=0
  - state RUN, `pend_pc`=0, counters 0
- Reset overrides everything, including mid-PEND; the latched redirect is discarded.
- Back-to-back flushes are impossible; the minimum spacing is 2 cycles because of BLANK.

## Configuration
- `CTRL_PERF_EN` defined:
  - `stall_cycles_o` increments every cycle with `stall`≠0, saturating at 32'hFFFF_FFFF.
  - `flush_count_o` increments per flush and wraps.
  - Both clear on `rst`.
- `CTRL_PERF_EN` undefined: the counter ports and logic are absent; the rest of the behaviour is identical.

## Test plan
- `stallreq_ex`=1 and `stallreq_if`=1 together → `stall`=6'b001111 and `flush`=0. Dropping both → `stall`=0 the next cycle.
- `excepttype_i`=32'h8 in RUN → same cycle `flush`=1, `new_pc`=32'h8000_0180, `stall`=0. Next cycle `stallreq_mem`=1 is ignored (`stall`=0).
- `excepttype_i`=32'h0E, `cp0_epc_i`=32'hBFC0_0100 with `stallreq_mem`=1 for 3 cycles → `stall`=6'b011111 for 3 cycles, no flush. On the 4th cycle `flush`=1 and `new_pc`=32'hBFC0_0100, even if `cp0_epc_i` changed meanwhile.
- `tlb_refetch_i`=1 with `refetch_pc_i`=32'hFFFF_FFFC → `flush`=1, `new_pc`=32'h0000_0000 (wrap).
- `rst`=1 in PEND, then release with `stallreq_mem`=0 → no flush, state RUN.
- With `CTRL_PERF_EN`: 5 stall cycles and 2 flushes → `stall_cycles_o`=5, `flush_count_o`=2.
